baccarat_dealer: RTL and testbench

Sequencing controller for one baccarat hand. It latches the six card slots from the upstream card source (`new_card`, one card value per clock). It presents those slots to the two hand-scoring instances (player and dealer) and reads their mod-10 scores back. From those scores it applies the natural, player-third-card and banker-third-card rules. It then registers the result onto the win lights and holds it until reset or `new_game`.

---
 rtl/baccarat_dealer.sv | 146 ++++++++++++++
 tb/tb_baccarat_dealer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/baccarat_dealer.sv
// Baccarat hand sequencer: deals six card slots, applies the natural and
// third-card rules from the external scorers, and latches the win lights.
module baccarat_dealer (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] new_card,
  input  logic       new_game,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       done
);

  localparam int unsigned CARD_W  = 4;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_DEAL_P1   = 3'd0;
  localparam logic [STATE_W-1:0] S_DEAL_D1   = 3'd1;
  localparam logic [STATE_W-1:0] S_DEAL_P2   = 3'd2;
  localparam logic [STATE_W-1:0] S_DEAL_D2   = 3'd3;
  localparam logic [STATE_W-1:0] S_EVAL      = 3'd4;
  localparam logic [STATE_W-1:0] S_BANK_EVAL = 3'd5;
  localparam logic [STATE_W-1:0] S_RESULT    = 3'd6;
  localparam logic [STATE_W-1:0] S_DONE      = 3'd7;

  logic [STATE_W-1:0] state, state_d;
  logic [CARD_W-1:0]  pcard1_d, pcard2_d, pcard3_d;
  logic [CARD_W-1:0]  dcard1_d, dcard2_d, dcard3_d;
  logic               player_win_d, dealer_win_d, done_d;
  logic [CARD_W-1:0]  p3v;
  logic               bank_draw;

  // Banker third-card table, indexed by banker score and player's third card value
  always_comb begin
    p3v       = (pcard3 <= CARD_W'(9)) ? pcard3 : '0;
    bank_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: bank_draw = 1'b1;
      4'd3:             bank_draw = (p3v != 4'd8);
      4'd4:             bank_draw = (p3v >= 4'd2) && (p3v <= 4'd7);
      4'd5:             bank_draw = (p3v >= 4'd4) && (p3v <= 4'd7);
      4'd6:             bank_draw = (p3v >= 4'd6) && (p3v <= 4'd7);
      default:          bank_draw = 1'b0;
    endcase
  end

  // Next-state and next-register values
  always_comb begin
    state_d      = state;
    pcard1_d     = pcard1;
    pcard2_d     = pcard2;
    pcard3_d     = pcard3;
    dcard1_d     = dcard1;
    dcard2_d     = dcard2;
    dcard3_d     = dcard3;
    player_win_d = player_win_light;
    dealer_win_d = dealer_win_light;
    case (state)
      S_DEAL_P1: begin
        pcard1_d = new_card;
        state_d  = S_DEAL_D1;
      end
      S_DEAL_D1: begin
        dcard1_d = new_card;
        state_d  = S_DEAL_P2;
      end
      S_DEAL_P2: begin
        pcard2_d = new_card;
        state_d  = S_DEAL_D2;
      end
      S_DEAL_D2: begin
        dcard2_d = new_card;
        state_d  = S_EVAL;
      end
      S_EVAL: begin
        if ((pscore >= 4'd8) || (dscore >= 4'd8)) begin
          state_d = S_RESULT;
        end else if (pscore <= 4'd5) begin
          pcard3_d = new_card;
          state_d  = S_BANK_EVAL;
        end else begin
          if (dscore <= 4'd5) dcard3_d = new_card;
          state_d = S_RESULT;
        end
      end
      S_BANK_EVAL: begin
        if (bank_draw) dcard3_d = new_card;
        state_d = S_RESULT;
      end
      S_RESULT: begin
        player_win_d = (pscore >= dscore);
        dealer_win_d = (dscore >= pscore);
        state_d      = S_DONE;
      end
      S_DONE: begin
        if (new_game) begin
          pcard1_d     = '0;
          pcard2_d     = '0;
          pcard3_d     = '0;
          dcard1_d     = '0;
          dcard2_d     = '0;
          dcard3_d     = '0;
          player_win_d = 1'b0;
          dealer_win_d = 1'b0;
          state_d      = S_DEAL_P1;
        end
      end
      default: state_d = S_DEAL_P1;
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state            <= S_DEAL_P1;
      pcard1           <= '0;
      pcard2           <= '0;
      pcard3           <= '0;
      dcard1           <= '0;
      dcard2           <= '0;
      dcard3           <= '0;
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
      done             <= 1'b0;
    end else begin
      state            <= state_d;
      pcard1           <= pcard1_d;
      pcard2           <= pcard2_d;
      pcard3           <= pcard3_d;
      dcard1           <= dcard1_d;
      dcard2           <= dcard2_d;
      dcard3           <= dcard3_d;
      player_win_light <= player_win_d;
      dealer_win_light <= dealer_win_d;
      done             <= done_d;
    end
  end

endmodule

// File: tb/tb_baccarat_dealer.sv
// Scoreboard bench for baccarat_dealer: directed hands with hand-computed
// outcomes; a negedge monitor checks each hand when done rises.
module tb_baccarat_dealer;

  logic       clk = 1'b0;
  logic       resetb;
  logic [3:0] new_card;
  logic       new_game;
  logic [3:0] pscore, dscore;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic       player_win_light, dealer_win_light, done;

  baccarat_dealer dut (
    .slow_clock(clk), .resetb(resetb), .new_card(new_card), .new_game(new_game),
    .pscore(pscore), .dscore(dscore),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .player_win_light(player_win_light), .dealer_win_light(dealer_win_light),
    .done(done)
  );

  always #5 clk = ~clk;

  // Reference hand scorer: ace..9 at face value, 10/J/Q/K and out-of-range count 0
  function automatic int card_val(input logic [3:0] c);
    return (c <= 4'd9) ? int'(c) : 0;
  endfunction
  function automatic logic [3:0] score(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return 4'((card_val(a) + card_val(b) + card_val(c)) % 10);
  endfunction
  assign pscore = score(pcard1, pcard2, pcard3);
  assign dscore = score(dcard1, dcard2, dcard3);

  typedef struct {
    int          kind;       // 0: hand result at done rise, 1: all-clear check now
    logic [23:0] cards;      // {p1,p2,p3,d1,d2,d3}
    logic [1:0]  lights;     // {player,dealer}
    int          exp_edge;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   edges = 0;
  int   checks = 0;
  int   errors = 0;
  bit   seen_done = 1'b0;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clk) begin
    exp_t cur;
    logic [23:0] act_cards;
    act_cards = {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3};
    if (sb.size() > 0) begin
      cur = sb[0];
      if (cur.kind == 1) begin
        void'(sb.pop_front());
        check({cur.name, "_cards"}, 32'(act_cards), 32'(cur.cards));
        check({cur.name, "_lights"}, 32'({player_win_light, dealer_win_light}), 32'(cur.lights));
        check({cur.name, "_done"}, 32'(done), 32'(0));
      end else if (done && !seen_done) begin
        void'(sb.pop_front());
        check({cur.name, "_cards"}, 32'(act_cards), 32'(cur.cards));
        check({cur.name, "_lights"}, 32'({player_win_light, dealer_win_light}), 32'(cur.lights));
        check({cur.name, "_edge"}, 32'(edges), 32'(cur.exp_edge));
      end else if (edges > cur.exp_edge) begin
        void'(sb.pop_front());
        checks++;
        errors++;
        $display("FAIL %s_timeout: done not seen by edge %0d (now %0d)", cur.name, cur.exp_edge, edges);
      end
    end
    seen_done = done;
  end

  task automatic push_clear(input string nm);
    exp_t e;
    e.kind = 1; e.cards = '0; e.lights = 2'b00; e.exp_edge = 0; e.name = nm;
    sb.push_back(e);
  endtask

  // Called at posedge+1 with the DUT in DEAL_P1; cs holds six offered cards
  task automatic play_hand(input string nm, input logic [23:0] cs, input logic [23:0] ecards,
                           input logic [1:0] elights, input int n, input bit ng_in_deal);
    exp_t e;
    logic [23:0] cv;
    cv = cs;
    e.kind = 0; e.cards = ecards; e.lights = elights; e.exp_edge = edges + n; e.name = nm;
    sb.push_back(e);
    for (int i = 0; i < 6; i++) begin
      new_card = cv[23-4*i -: 4];
      new_game = ng_in_deal && (i < 4);
      @(posedge clk); #1;
    end
    new_game = 1'b0;
    new_card = 4'd9;
    for (int k = 0; k < 4 && !done; k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic restart(input string nm);
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    push_clear(nm);
  endtask

  initial begin
    resetb   = 1'b0;
    new_card = 4'd0;
    new_game = 1'b0;
    push_clear("reset_init");
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;

    // p=8 natural vs d=7
    play_hand("natural", {4'd3,4'd5,4'd5,4'd2,4'd9,4'd9},
              {4'd3,4'd5,4'd0, 4'd5,4'd2,4'd0}, 2'b10, 6, 1'b0);
    restart("ng_clear1");
    // p=3 draws 4, banker 5 with p3v=4 draws K; new_game held during deal
    play_hand("both_draw", {4'd1,4'd2,4'd2,4'd3,4'd4,4'd13},
              {4'd1,4'd2,4'd4, 4'd2,4'd3,4'd13}, 2'b10, 7, 1'b1);
    restart("ng_clear2");
    // player stands on 6, banker 2 draws 5 -> 7
    play_hand("stand_draw", {4'd6,4'd1,4'd10,4'd1,4'd5,4'd9},
              {4'd6,4'd10,4'd0, 4'd1,4'd1,4'd5}, 2'b01, 6, 1'b0);
    restart("ng_clear3");

    // Reset asserted after edge 3 of a deal
    new_card = 4'd7; @(posedge clk); #1;
    new_card = 4'd7; @(posedge clk); #1;
    new_card = 4'd7; @(posedge clk); #1;
    resetb = 1'b0;
    push_clear("reset_mid");
    @(posedge clk); #1;
    resetb = 1'b1;

    // banker 6 stands against p3v=8
    play_hand("bank6_stand", {4'd2,4'd3,4'd1,4'd3,4'd8,4'd9},
              {4'd2,4'd1,4'd8, 4'd3,4'd3,4'd0}, 2'b01, 7, 1'b0);
    restart("ng_clear4");
    // face cards, both draw, 0-0 tie
    play_hand("tie_faces", {4'd10,4'd11,4'd10,4'd11,4'd12,4'd13},
              {4'd10,4'd10,4'd12, 4'd11,4'd11,4'd13}, 2'b11, 7, 1'b0);
    restart("ng_clear5");
    // player stands on 7, banker stands on 6
    play_hand("both_stand", {4'd4,4'd3,4'd3,4'd3,4'd5,4'd5},
              {4'd4,4'd3,4'd0, 4'd3,4'd3,4'd0}, 2'b10, 6, 1'b0);
    restart("ng_clear6");
    // banker 3 stands against p3v=8
    play_hand("bank3_vs8", {4'd1,4'd1,4'd2,4'd2,4'd8,4'd9},
              {4'd1,4'd2,4'd8, 4'd1,4'd2,4'd0}, 2'b01, 7, 1'b0);
    restart("ng_clear7");
    // out-of-range 15 stored as-is, p3v=0 so banker 4 stands
    play_hand("oor_card", {4'd1,4'd2,4'd1,4'd2,4'd15,4'd6},
              {4'd1,4'd1,4'd15, 4'd2,4'd2,4'd0}, 2'b01, 7, 1'b0);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
